// File: rtl/unidade_mult_div_if.sv
// Handshake and data bundle between the control unit and the multiply/divide unit.
// The control side drives start/operands/MTHI/MTLO and reads busy/done/HI/LO back.
interface unidade_mult_div_if #(
    parameter int LARGURA = 32
);
    logic               inicio;
    logic [1:0]         operacao;
    logic [LARGURA-1:0] operando_a;
    logic [LARGURA-1:0] operando_b;
    logic               escrita_hi;
    logic               escrita_lo;
    logic [LARGURA-1:0] dado_escrita;
    logic               ocupado;
    logic               pronto;
    logic               div_zero;
    logic [LARGURA-1:0] hi;
    logic [LARGURA-1:0] lo;

    modport master (
        output inicio, operacao, operando_a, operando_b,
        output escrita_hi, escrita_lo, dado_escrita,
        input  ocupado, pronto, div_zero, hi, lo
    );

    modport slave (
        input  inicio, operacao, operando_a, operando_b,
        input  escrita_hi, escrita_lo, dado_escrita,
        output ocupado, pronto, div_zero, hi, lo
    );
endinterface

// File: rtl/unidade_mult_div.sv
// MIPS MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide on magnitudes,
// sign fix-up on the final edge, results in dedicated HI/LO registers.
module unidade_mult_div #(
    parameter int LARGURA = 32,
    parameter int CICLOS  = LARGURA
) (
    input  logic clk,
    input  logic rst,
    unidade_mult_div_if.slave bus
);
    localparam int CW = $clog2(CICLOS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS - 1);

    typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE} estado_t;

    estado_t                estado_reg;
    logic [CW-1:0]          contador_reg;
    logic                   prep_reg;
    logic                   op_div_reg;
    logic                   sinal_res_reg;
    logic                   sinal_rest_reg;
    logic                   zero_reg;
    logic [LARGURA-1:0]     a_abs_reg;
    logic [LARGURA-1:0]     b_abs_reg;
    logic [2*LARGURA-1:0]   acc_reg;
    logic [LARGURA-1:0]     hi_reg;
    logic [LARGURA-1:0]     lo_reg;
    logic                   ocupado_reg;
    logic                   pronto_reg;
    logic                   div_zero_reg;

    logic                   op_sinal;
    logic                   neg_a;
    logic                   neg_b;
    logic [LARGURA-1:0]     abs_a;
    logic [LARGURA-1:0]     abs_b;
    logic [LARGURA:0]       soma_mult;
    logic [LARGURA:0]       resto_desl;
    logic [LARGURA-1:0]     diferenca;
    logic [2*LARGURA-1:0]   passo_mult;
    logic [2*LARGURA-1:0]   passo_div;
    logic [2*LARGURA-1:0]   produto_final;
    logic [LARGURA-1:0]     quociente_final;
    logic [LARGURA-1:0]     resto_final;

    always_comb begin
        op_sinal = ~bus.operacao[0];
        neg_a    = op_sinal & bus.operando_a[LARGURA-1];
        neg_b    = op_sinal & bus.operando_b[LARGURA-1];
        abs_a    = neg_a ? -bus.operando_a : bus.operando_a;
        abs_b    = neg_b ? -bus.operando_b : bus.operando_b;

        // acc holds {partial product, remaining multiplier bits} while multiplying
        soma_mult  = {1'b0, acc_reg[2*LARGURA-1:LARGURA]} + (acc_reg[0] ? {1'b0, a_abs_reg} : '0);
        passo_mult = {soma_mult, acc_reg[LARGURA-1:1]};

        // and {remainder, dividend bits shifting into quotient} while dividing
        resto_desl = {acc_reg[2*LARGURA-1:LARGURA], acc_reg[LARGURA-1]};
        diferenca  = resto_desl[LARGURA-1:0] - b_abs_reg;
        if (resto_desl >= {1'b0, b_abs_reg}) begin
            passo_div = {diferenca, acc_reg[LARGURA-2:0], 1'b1};
        end else begin
            passo_div = {resto_desl[LARGURA-1:0], acc_reg[LARGURA-2:0], 1'b0};
        end

        produto_final = sinal_res_reg ? -acc_reg : acc_reg;
        resto_final   = sinal_rest_reg ? -acc_reg[2*LARGURA-1:LARGURA] : acc_reg[2*LARGURA-1:LARGURA];
        // With a zero divisor the remainder path already reproduces the dividend
        if (zero_reg) begin
            quociente_final = '1;
        end else begin
            quociente_final = sinal_res_reg ? -acc_reg[LARGURA-1:0] : acc_reg[LARGURA-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_reg     <= OCIOSO;
            contador_reg   <= '0;
            prep_reg       <= 1'b0;
            op_div_reg     <= 1'b0;
            sinal_res_reg  <= 1'b0;
            sinal_rest_reg <= 1'b0;
            zero_reg       <= 1'b0;
            a_abs_reg      <= '0;
            b_abs_reg      <= '0;
            acc_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            ocupado_reg    <= 1'b0;
            pronto_reg     <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            pronto_reg <= 1'b0;
            case (estado_reg)
                OCIOSO: begin
                    if (bus.inicio) begin
                        op_div_reg     <= bus.operacao[1];
                        a_abs_reg      <= abs_a;
                        b_abs_reg      <= abs_b;
                        sinal_res_reg  <= neg_a ^ neg_b;
                        sinal_rest_reg <= neg_a & bus.operacao[1];
                        zero_reg       <= bus.operacao[1] & (bus.operando_b == '0);
                        div_zero_reg   <= 1'b0;
                        contador_reg   <= '0;
                        prep_reg       <= 1'b1;
                        estado_reg     <= CALCULA;
                    end else begin
                        if (bus.escrita_hi) hi_reg <= bus.dado_escrita;
                        if (bus.escrita_lo) lo_reg <= bus.dado_escrita;
                    end
                end
                CALCULA: begin
                    ocupado_reg <= 1'b1;
                    // First edge only seeds the accumulator; the iterations follow
                    if (prep_reg) begin
                        prep_reg <= 1'b0;
                        acc_reg  <= {{LARGURA{1'b0}}, (op_div_reg ? a_abs_reg : b_abs_reg)};
                    end else begin
                        acc_reg      <= op_div_reg ? passo_div : passo_mult;
                        contador_reg <= contador_reg + 1'b1;
                        if (contador_reg == ULTIMO) estado_reg <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    if (op_div_reg) begin
                        hi_reg <= resto_final;
                        lo_reg <= quociente_final;
                    end else begin
                        hi_reg <= produto_final[2*LARGURA-1:LARGURA];
                        lo_reg <= produto_final[LARGURA-1:0];
                    end
                    div_zero_reg <= zero_reg;
                    pronto_reg   <= 1'b1;
                    ocupado_reg  <= 1'b0;
                    estado_reg   <= OCIOSO;
                end
                default: estado_reg <= OCIOSO;
            endcase
        end
    end

    assign bus.ocupado  = ocupado_reg;
    assign bus.pronto   = pronto_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for unidade_mult_div: vector table of operations plus handshake,
// MTHI/MTLO and reset sequences, all checked against hand-computed values.
module tb_unidade_mult_div;
    logic clk;
    logic rst;
    int   testes;
    int   falhas;

    unidade_mult_div_if #(.LARGURA(32)) bus ();

    unidade_mult_div #(.LARGURA(32), .CICLOS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vetor_t;

    vetor_t vet [12];

    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic escreve_mt(input logic wr_hi, input logic wr_lo, input logic [31:0] dado);
        bus.escrita_hi   = wr_hi;
        bus.escrita_lo   = wr_lo;
        bus.dado_escrita = dado;
        ciclo();
        bus.escrita_hi = 1'b0;
        bus.escrita_lo = 1'b0;
    endtask

    task automatic espera_sem_pronto(input int ciclos, input string nome);
        int cnt;
        cnt = 0;
        for (int i = 0; i < ciclos; i++) begin
            ciclo();
            if (bus.pronto) cnt++;
        end
        chk(nome, cnt, 0);
    endtask

    // Starts an operation from the current cycle and returns in the cycle pronto is high.
    // inj > 0 pulses a competing inicio at that cycle and an MTLO two cycles later.
    task automatic run_op(input string nome, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj, input logic com_escrita);
        int          n;
        bit          visto;
        bit          ocup_ok;
        logic [31:0] hi_antes;
        logic [31:0] lo_antes;
        hi_antes          = bus.hi;
        lo_antes          = bus.lo;
        bus.inicio        = 1'b1;
        bus.operacao      = op;
        bus.operando_a    = a;
        bus.operando_b    = b;
        bus.escrita_hi    = com_escrita;
        bus.escrita_lo    = com_escrita;
        bus.dado_escrita  = 32'hDEAD_BEEF;
        ciclo();
        bus.inicio     = 1'b0;
        bus.escrita_hi = 1'b0;
        bus.escrita_lo = 1'b0;
        bus.operando_a = $urandom;
        bus.operando_b = $urandom;
        bus.operacao   = op ^ 2'b10;
        chk({nome, "_dz_limpo"}, bus.div_zero, 1'b0);
        if (com_escrita) begin
            chk({nome, "_mthi_perde"}, bus.hi, hi_antes);
            chk({nome, "_mtlo_perde"}, bus.lo, lo_antes);
        end
        visto   = 1'b0;
        ocup_ok = 1'b1;
        n       = 0;
        while (!visto && n < 40) begin
            ciclo();
            n++;
            bus.inicio     = 1'b0;
            bus.escrita_lo = 1'b0;
            if (inj > 0 && n == inj) begin
                bus.inicio     = 1'b1;
                bus.operacao   = 2'b11;
                bus.operando_a = 32'd100;
                bus.operando_b = 32'd7;
            end
            if (inj > 0 && n == inj + 2) begin
                bus.escrita_lo   = 1'b1;
                bus.dado_escrita = 32'h1234;
            end
            if (inj > 0 && n == inj + 4) chk({nome, "_mtlo_ocupado"}, bus.lo, lo_antes);
            if (bus.pronto) visto = 1'b1;
            else if (!bus.ocupado) ocup_ok = 1'b0;
        end
        bus.inicio     = 1'b0;
        bus.escrita_lo = 1'b0;
        chk({nome, "_latencia"}, n, 34);
        chk({nome, "_ocupado"}, ocup_ok, 1'b1);
        chk({nome, "_ocupado_fim"}, bus.ocupado, 1'b0);
    endtask

    initial begin
        testes = 0;
        falhas = 0;
        rst = 1'b0;
        bus.inicio = 1'b0;
        bus.operacao = 2'b00;
        bus.operando_a = '0;
        bus.operando_b = '0;
        bus.escrita_hi = 1'b0;
        bus.escrita_lo = 1'b0;
        bus.dado_escrita = '0;

        vet[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vet[1]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vet[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vet[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vet[4]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vet[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vet[6]  = '{2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vet[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vet[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vet[9]  = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vet[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vet[11] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        ciclo();
        ciclo();
        rst = 1'b1;
        ciclo();

        // Reset with HI/LO preloaded
        escreve_mt(1'b1, 1'b1, 32'hCAFE_F00D);
        chk("mt_ambos_hi", bus.hi, 32'hCAFE_F00D);
        chk("mt_ambos_lo", bus.lo, 32'hCAFE_F00D);
        rst = 1'b0;
        ciclo();
        ciclo();
        rst = 1'b1;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk("reset_ocupado", bus.ocupado, 1'b0);
        chk("reset_pronto", bus.pronto, 1'b0);
        chk("reset_dz", bus.div_zero, 1'b0);
        ciclo();

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vet[i].op, vet[i].a, vet[i].b, 0, 1'b0);
            chk($sformatf("v%0d_hi", i), bus.hi, vet[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo, vet[i].lo);
            chk($sformatf("v%0d_dz", i), bus.div_zero, vet[i].dz);
            $display("[TB] op=%b a=%h b=%h -> hi=%h lo=%h dz=%b", vet[i].op, vet[i].a, vet[i].b,
                     bus.hi, bus.lo, bus.div_zero);
            espera_sem_pronto(1, $sformatf("v%0d_pulso", i));
            chk($sformatf("v%0d_hi_mantem", i), bus.hi, vet[i].hi);
        end

        // Competing inicio and MTLO while busy
        run_op("ignora", 2'b01, 32'd3, 32'd5, 10, 1'b0);
        chk("ignora_hi", bus.hi, 32'd0);
        chk("ignora_lo", bus.lo, 32'd15);
        espera_sem_pronto(40, "ignora_pronto_unico");

        // Back-to-back: second inicio raised in the pronto cycle
        run_op("seq1", 2'b11, 32'd100, 32'd7, 0, 1'b0);
        chk("seq1_lo", bus.lo, 32'd14);
        run_op("seq2", 2'b01, 32'd6, 32'd7, 0, 1'b0);
        chk("seq2_hi", bus.hi, 32'd0);
        chk("seq2_lo", bus.lo, 32'd42);
        ciclo();

        // MTLO while idle
        escreve_mt(1'b0, 1'b1, 32'h1234);
        chk("mtlo_ocioso", bus.lo, 32'h1234);
        chk("mtlo_hi_intacto", bus.hi, 32'd0);
        $display("[TB] mtlo idle -> lo=%h", bus.lo);

        // inicio together with write strobes: inicio wins
        run_op("inicio_vs_mt", 2'b01, 32'd2, 32'd3, 0, 1'b1);
        chk("inicio_vs_mt_lo", bus.lo, 32'd6);
        ciclo();

        // Reset in the middle of a MULTU
        bus.inicio     = 1'b1;
        bus.operacao   = 2'b01;
        bus.operando_a = 32'hFFFFFFFF;
        bus.operando_b = 32'hFFFFFFFF;
        ciclo();
        bus.inicio = 1'b0;
        repeat (14) ciclo();
        rst = 1'b0;
        ciclo();
        rst = 1'b1;
        chk("reset_meio_hi", bus.hi, 32'd0);
        chk("reset_meio_lo", bus.lo, 32'd0);
        chk("reset_meio_ocupado", bus.ocupado, 1'b0);
        espera_sem_pronto(40, "reset_meio_sem_pronto");
        run_op("pos_reset", 2'b01, 32'd7, 32'd9, 0, 1'b0);
        chk("pos_reset_lo", bus.lo, 32'd63);
        chk("pos_reset_hi", bus.hi, 32'd0);
        $display("[TB] post-reset multu 7*9 -> hi=%h lo=%h", bus.hi, bus.lo);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end
endmodule

// File: doc/unidade_mult_div.md
Name: unidade_mult_div

Overview:
Multi-cycle multiply/divide unit downstream of the register bank (banco). It consumes the two read ports (dado_leitura_1 → operando_a, dado_leitura_2 → operando_b) and computes MIPS-style MULT/MULTU/DIV/DIVU into dedicated HI/LO registers over 34 cycles. It uses a start/busy/done handshake so the control unit can stall while it runs. HI/LO are read by the writeback mux (MFHI/MFLO) and written directly on MTHI/MTLO.

Parameters:
LARGURA, 32, operand width; HI and LO are each LARGURA bits.
CICLOS, LARGURA, number of iteration cycles in CALCULA.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  one clock; reset is synchronous and active-low.
inicio  input  1  start request; sampled only in OCIOSO.
operacao  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with inicio.
operando_a  input  32  multiplicand/dividend, from dado_leitura_1.
operando_b  input  32  multiplier/divisor, from dado_leitura_2.
escrita_hi  input  1  MTHI strobe.
escrita_lo  input  1  MTLO strobe.
dado_escrita  input  32  data for MTHI/MTLO.
ocupado  output  1  high in CALCULA and AJUSTE.
pronto  output  1  one-cycle pulse when HI/LO are updated by an operation.
div_zero  output  1  set by DIV/DIVU with operando_b = 0; holds until the next accepted inicio.
hi  output  32  HI register (product upper half / remainder).
lo  output  32  LO register (product lower half / quotient).

Behaviour:
- Reset (rst=0 at a rising edge): state OCIOSO, hi=lo=0, ocupado=0, pronto=0, div_zero=0, counter=0. Reset aborts any operation in progress; no partial result reaches hi/lo.
- States: OCIOSO → CALCULA → AJUSTE → OCIOSO.
- OCIOSO:
  - inicio=1 at an edge latches operacao, operando_a and operando_b.
  - For signed ops, the unit stores absolute values plus the result signs. Result sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Clears div_zero and the counter, then goes to CALCULA.
  - inicio=0 keeps the unit in OCIOSO.
- CALCULA: exactly CICLOS edges, one bit per edge, counter 0..CICLOS-1. Move to AJUSTE when counter = CICLOS-1.
  - Multiply: shift-add into a 64-bit unsigned accumulator.
  - Divide: restoring shift-subtract, giving an unsigned quotient and remainder.
- AJUSTE: one edge.
  - Applies two's-complement sign correction for MULT/DIV.
  - Writes hi/lo and returns to OCIOSO.
  - The same edge sets pronto=1; pronto is cleared on the following edge.
- Latency: inicio sampled at edge k → pronto=1 and new hi/lo visible after edge k+CICLOS+2 (k+34 by default). ocupado is high from after edge k+1 through edge k+CICLOS+1.
- inicio while ocupado=1: ignored, not queued. inicio in the pronto cycle: accepted (the state is already OCIOSO).
- Operands are latched, so changes on operando_a/b after acceptance have no effect.
- Division by zero (operando_b=0, DIV or DIVU):
  - Still takes the full 34 cycles.
  - Result: hi=operando_a (as latched), lo=32'hFFFFFFFF, div_zero=1 with pronto.
- Signed overflow, DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, div_zero=0.
- Signed division truncates toward zero.
- MULT/MULTU produce the full 64-bit product: hi=bits 63:32, lo=bits 31:0.
- MTHI/MTLO:
  - In OCIOSO with inicio=0, escrita_hi/escrita_lo write dado_escrita to hi/lo at the edge; both may fire in the same cycle.
  - Ignored while ocupado=1.
  - If inicio=1 in the same cycle as a write strobe, inicio wins and the writes are dropped.
- hi/lo hold their values at all times except reset, the AJUSTE edge, or an accepted MTHI/MTLO.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with hi/lo preloaded by MTHI/MTLO → hi=lo=0, ocupado=0, pronto=0.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF, inicio at edge k → ocupado high until edge k+33, pronto pulse after edge k+34, hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT −1 × 2 → hi=32'hFFFFFFFF, lo=32'hFFFFFFFE. DIV −7/2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- Boundary divides:
  - DIVU 5/0 → hi=5, lo=32'hFFFFFFFF, div_zero=1. The next accepted inicio clears div_zero.
  - DIV 32'h80000000 / −1 → lo=32'h80000000, hi=0.
- Handshake:
  - inicio pulsed again at cycle 10 of an operation with different operands → ignored; first result intact; exactly one pronto.
  - Back-to-back inicio in the pronto cycle → second operation accepted.
  - escrita_lo with dado_escrita=32'h1234 while ocupado → lo unchanged. The same strobe in OCIOSO → lo=32'h1234.
- Reset mid-operation: rst=0 at cycle 15 of a MULTU → hi=lo=0, ocupado=0, no pronto ever pulses for that operation; a new operation afterwards completes correctly.
